// File: rtl/checker_pkg.sv
// Shared types for the store result checker: FSM state encoding and failure codes.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_BAD_ADR  = 2'd1;
  localparam logic [1:0] FC_BAD_DATA = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/store_hist_buf.sv
// Four-entry circular history of accepted stores; i_sel=0 reads the newest entry, 3 the oldest.
module store_hist_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_sel,
  output logic [31:0] o_adr,
  output logic [31:0] o_data
);

  logic [31:0] r_adr  [4];
  logic [31:0] r_data [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  w_rd_idx;

  // NOTE: the ring is only four entries, so it is cleared on reset to keep reads deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_adr[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_adr[r_wr_ptr]  <= i_adr;
      r_data[r_wr_ptr] <= i_data;
      r_wr_ptr         <= r_wr_ptr + 2'd1;
    end
  end

  // Pointer arithmetic wraps modulo 4, so newest = wr_ptr-1 and older entries step backwards.
  assign w_rd_idx = r_wr_ptr - 2'd1 - i_sel;
  assign o_adr    = r_adr[w_rd_idx];
  assign o_data   = r_data[w_rd_idx];

endmodule

// File: rtl/store_result_checker.sv
// End-of-test monitor judging committed stores against a pass/scratch address policy.
// Define STORE_HIST_EN to enable the 4-entry store history readback port.
module store_result_checker
  import checker_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [31:0]      data_adr,
  input  logic [31:0]      write_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_adr,
  output logic [31:0]      last_data,
  input  logic [1:0]       hist_sel,
  output logic [31:0]      hist_adr,
  output logic [31:0]      hist_data
);

  state_e           r_state;
  state_e           w_next_state;
  logic [1:0]       r_fail_code;
  logic [1:0]       w_next_code;
  logic [CNT_W-1:0] r_store_count;
  logic [CNT_W-1:0] r_cycle_count;
  logic [31:0]      r_last_adr;
  logic [31:0]      r_last_data;
  logic             w_accept;
  logic             w_timeout_hit;

  assign w_accept = (r_state == RUN) && mem_write;

  // Zero-extended count never equals TIMEOUT_CYCLES-1 when that exceeds the counter range.
  assign w_timeout_hit = (64'(r_cycle_count) == (64'(TIMEOUT_CYCLES) - 64'd1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fail_code <= FC_NONE;
    end else begin
      r_state     <= w_next_state;
      r_fail_code <= w_next_code;
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_fail_code;
    unique case (r_state)
      IDLE: w_next_state = RUN;
      RUN: begin
        if (mem_write && (data_adr == PASS_ADDR)) begin
          if (write_data == PASS_DATA) begin
            w_next_state = PASS;
          end else begin
            w_next_state = FAIL;
            w_next_code  = FC_BAD_DATA;
          end
        end else if (mem_write && (data_adr != SCRATCH_ADDR)) begin
          w_next_state = FAIL;
          w_next_code  = FC_BAD_ADR;
        end else if (w_timeout_hit) begin
          w_next_state = FAIL;
          w_next_code  = FC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pass      = (r_state == PASS);
    fail      = (r_state == FAIL);
    done      = pass | fail;
    fail_code = r_fail_code;
  end

  // Counters and last_* only move in RUN, which freezes them once a verdict is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store_count <= '0;
      r_cycle_count <= '0;
      r_last_adr    <= '0;
      r_last_data   <= '0;
    end else if (r_state == RUN) begin
      if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
      if (mem_write) begin
        if (r_store_count != '1) r_store_count <= r_store_count + 1'b1;
        r_last_adr  <= data_adr;
        r_last_data <= write_data;
      end
    end
  end

  assign store_count = r_store_count;
  assign cycle_count = r_cycle_count;
  assign last_adr    = r_last_adr;
  assign last_data   = r_last_data;

`ifdef STORE_HIST_EN
  store_hist_buf u_hist (
    .clk     (clk),
    .reset   (reset),
    .i_wr_en (w_accept),
    .i_adr   (data_adr),
    .i_data  (write_data),
    .i_sel   (hist_sel),
    .o_adr   (hist_adr),
    .o_data  (hist_data)
  );
`else
  logic w_unused_hist;
  assign w_unused_hist = ^{hist_sel, w_accept};
  assign hist_adr      = '0;
  assign hist_data     = '0;
`endif

endmodule
